// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem request/response, decode handshake and redirect bundle for the fetch stage
interface instruction_fetch_if;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_imem_rsp_err;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_fault;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    modport master (
        output o_imem_req_valid, o_imem_req_addr, o_inst_valid, o_inst, o_inst_pc, o_inst_fault,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_inst_ready,
               i_redirect_valid, i_redirect_pc
    );
    modport slave (
        input  o_imem_req_valid, o_imem_req_addr, o_inst_valid, o_inst, o_inst_pc, o_inst_fault,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_inst_ready,
               i_redirect_valid, i_redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the fetch PC, issues credit-limited imem reads and buffers PC-tagged instructions for decode
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input logic          i_clock,
    input logic          i_reset,
    instruction_fetch_if.master io_bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0] r_fifo_data [FIFO_DEPTH];
    logic [31:0] r_fifo_pc   [FIFO_DEPTH];
    logic        r_fifo_err  [FIFO_DEPTH];

    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_out_next;
    logic [31:0]   w_redirect_pc;
    logic          w_req_fire;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;

    // Credit: requests in flight plus buffered entries never exceed the FIFO depth, so pushes always fit
    assign w_inflight     = r_outstanding + r_count;
    assign w_redirect_pc  = io_bus.i_redirect_pc & ~32'h3;
    assign w_req_fire     = io_bus.o_imem_req_valid & io_bus.i_imem_req_ready;
    assign w_drop         = r_drop_cnt != '0;
    assign w_push         = io_bus.i_imem_rsp_valid & ~w_drop;
    assign w_pop          = io_bus.o_inst_valid & io_bus.i_inst_ready;
    assign w_out_next     = r_outstanding + CW'(w_req_fire) - CW'(io_bus.i_imem_rsp_valid);

    assign io_bus.o_imem_req_valid = ~i_reset & (w_inflight < CW'(FIFO_DEPTH));
    assign io_bus.o_imem_req_addr  = r_fetch_pc;
    assign io_bus.o_inst_valid     = ~i_reset & (r_count != '0);
    assign io_bus.o_inst           = r_fifo_data[r_rptr];
    assign io_bus.o_inst_pc        = r_fifo_pc[r_rptr];
    assign io_bus.o_inst_fault     = r_fifo_err[r_rptr];

    // PC, credit and FIFO bookkeeping; a redirect flushes the buffer and marks every in-flight response stale
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (io_bus.i_redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= w_out_next;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (io_bus.i_imem_rsp_valid & w_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wptr   <= r_wptr + AW'(1);
                end
                if (w_pop) r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by the count and pointers
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= io_bus.i_imem_rsp_data;
            r_fifo_pc[r_wptr]   <= r_rsp_pc;
            r_fifo_err[r_wptr]  <= io_bus.i_imem_rsp_err;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors plus hand sequences against an in-order latency memory model
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus();
    instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .io_bus (bus)
    );

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] err_addr = 32'h1;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic fault; } inst_t;
    typedef struct { logic rv; logic [31:0] ra; logic iv; logic [31:0] ipc; } vec_t;
    req_t  q[$];
    logic [31:0] req_log[$];
    inst_t inst_log[$];
    vec_t  vt[6];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model and monitors: everything sampled and driven mid-cycle, away from the active edge
    always @(negedge clk) begin
        cyc++;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        bus.i_imem_rsp_err   = 1'b0;
        if (rst) begin
            q.delete();
            req_log.delete();
            inst_log.delete();
        end else begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                req_t r;
                r = q.pop_front();
                bus.i_imem_rsp_valid = 1'b1;
                bus.i_imem_rsp_data  = mdata(r.addr);
                bus.i_imem_rsp_err   = (r.addr == err_addr);
            end
            if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
                q.push_back('{bus.o_imem_req_addr, cyc + lat});
                req_log.push_back(bus.o_imem_req_addr);
            end
            if (bus.o_inst_valid && bus.i_inst_ready)
                inst_log.push_back('{bus.o_inst_pc, bus.o_inst, bus.o_inst_fault});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] ipc(input int i);
        return i < inst_log.size() ? inst_log[i].pc : 32'hx;
    endfunction
    function automatic logic [31:0] idata(input int i);
        return i < inst_log.size() ? inst_log[i].data : 32'hx;
    endfunction
    function automatic logic [31:0] ifault(input int i);
        return i < inst_log.size() ? {31'b0, inst_log[i].fault} : 32'hx;
    endfunction
    function automatic logic [31:0] rq(input int i);
        return i < req_log.size() ? req_log[i] : 32'hx;
    endfunction

    initial begin
        int m;
        vt[0] = '{1'b1, 32'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 32'h04, 1'b0, 32'h0};
        vt[2] = '{1'b1, 32'h08, 1'b1, 32'h0};
        vt[3] = '{1'b1, 32'h0C, 1'b1, 32'h4};
        vt[4] = '{1'b1, 32'h10, 1'b1, 32'h8};
        vt[5] = '{1'b1, 32'h14, 1'b1, 32'hC};
        bus.i_imem_req_ready = 1'b1;
        bus.i_inst_ready     = 1'b1;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = 32'h0;

        rst = 1'b1;
        repeat (3) tick();
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = 32'h500;
        #1;
        chk("rst_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, bus.o_inst_valid}, 32'd0);
        tick();
        bus.i_redirect_valid = 1'b0;

        // Streaming with 1-cycle memory, decode always ready
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t1_rv%0d", i), {31'b0, bus.o_imem_req_valid}, {31'b0, vt[i].rv});
            chk($sformatf("t1_ra%0d", i), bus.o_imem_req_addr, vt[i].ra);
            chk($sformatf("t1_iv%0d", i), {31'b0, bus.o_inst_valid}, {31'b0, vt[i].iv});
            if (vt[i].iv) begin
                chk($sformatf("t1_pc%0d", i), bus.o_inst_pc, vt[i].ipc);
                chk($sformatf("t1_data%0d", i), bus.o_inst, mdata(vt[i].ipc));
                chk($sformatf("t1_fault%0d", i), {31'b0, bus.o_inst_fault}, 32'd0);
            end
            tick();
        end

        // Backpressure from the start: credit stops at 4 requests, then drains in order
        bus.i_inst_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        chk("t2_nreq", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_req%0d", i), rq(i), 32'(4 * i));
        chk("t2_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
        chk("t2_inst_valid", {31'b0, bus.o_inst_valid}, 32'd1);
        chk("t2_hold_pc", bus.o_inst_pc, 32'h0);
        bus.i_inst_ready = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_pc%0d", i), ipc(i), 32'(4 * i));
            chk($sformatf("t2_data%0d", i), idata(i), mdata(32'(4 * i)));
        end
        chk("t2_resume", rq(4), 32'h10);

        // 3-cycle memory, redirect with 0x8 and 0xC outstanding
        lat = 3;
        do_reset();
        repeat (4) tick();
        chk("t3_nreq", 32'(req_log.size()), 32'd4);
        chk("t3_out8", rq(2), 32'h8);
        chk("t3_outC", rq(3), 32'hC);
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = 32'h100;
        tick();
        bus.i_redirect_valid = 1'b0;
        chk("t3_addr", bus.o_imem_req_addr, 32'h100);
        repeat (8) tick();
        chk("t3_req4", rq(4), 32'h100);
        chk("t3_req5", rq(5), 32'h104);
        chk("t3_pc0", ipc(0), 32'h0);
        chk("t3_pc1", ipc(1), 32'h100);
        chk("t3_data1", idata(1), mdata(32'h100));
        chk("t3_pc2", ipc(2), 32'h104);

        // Misaligned redirect target is forced to a word boundary
        lat = 1;
        do_reset();
        repeat (5) tick();
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = 32'h206;
        tick();
        bus.i_redirect_valid = 1'b0;
        chk("t4_addr", bus.o_imem_req_addr, 32'h204);
        chk("t4_valid", {31'b0, bus.o_imem_req_valid}, 32'd1);
        m = inst_log.size();
        repeat (4) tick();
        chk("t4_pc0", ipc(m), 32'h204);
        chk("t4_pc1", ipc(m + 1), 32'h208);

        // Address wrap at the top of the 32-bit space
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.i_redirect_valid = 1'b0;
        chk("t5_addr0", bus.o_imem_req_addr, 32'hFFFF_FFFC);
        m = inst_log.size();
        tick();
        chk("t5_addr1", bus.o_imem_req_addr, 32'h0);
        repeat (4) tick();
        chk("t5_pc0", ipc(m), 32'hFFFF_FFFC);
        chk("t5_pc1", ipc(m + 1), 32'h0);
        chk("t5_data1", idata(m + 1), mdata(32'h0));

        // Access fault tagging, then reset with entries buffered
        err_addr = 32'h8;
        do_reset();
        repeat (8) tick();
        chk("t6_fault1", ifault(1), 32'd0);
        chk("t6_pc2", ipc(2), 32'h8);
        chk("t6_fault2", ifault(2), 32'd1);
        chk("t6_pc3", ipc(3), 32'hC);
        chk("t6_fault3", ifault(3), 32'd0);
        chk("t6_data3", idata(3), mdata(32'hC));
        err_addr = 32'h1;
        bus.i_inst_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        chk("t6_buf_valid", {31'b0, bus.o_inst_valid}, 32'd1);
        chk("t6_buf_pc", bus.o_inst_pc, 32'h0);
        rst = 1'b1;
        #1;
        chk("t6_rst_inst_valid", {31'b0, bus.o_inst_valid}, 32'd0);
        chk("t6_rst_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_post_inst_valid", {31'b0, bus.o_inst_valid}, 32'd0);
        chk("t6_post_req_valid", {31'b0, bus.o_imem_req_valid}, 32'd1);
        chk("t6_post_addr", bus.o_imem_req_addr, 32'h0);
        repeat (3) tick();
        chk("t6_first_req", rq(0), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
